// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared widths, FSM states and in-flight tag type for the perceptron sequencer
package perceptron_pkg;
  localparam int LANE_W = 18;
  localparam int SUM_W = 48;
  localparam int IDX_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/perceptron_seq_tag_pipe.sv
// tag_pipe: DEPTH-stage shift register tracking which neuron each cascade slot belongs to
module tag_pipe
  import perceptron_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);
  tag_t sr_q [DEPTH];
  tag_t sr_d [DEPTH];
  always_comb begin
    sr_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '{default: '0};
    else sr_q <= sr_d;
  end
  assign tag_o = sr_q[DEPTH-1];
endmodule

// File: rtl/perceptron_seq.sv
// perceptron_seq: time-multiplexes one weighted_sum cascade across NEURONS perceptrons sharing an input vector
module perceptron_seq
  import perceptron_pkg::*;
#(
  parameter int N = 8,
  parameter int NEURONS = 4,
  parameter int PIPE_LAT = 10,
  parameter int AW = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANE_W*N-1:0]        in_x,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [LANE_W*N-1:0]        wr_w,
  output logic                       busy,
  input  logic [SUM_W-1:0]           thresh,
  output logic [LANE_W*N-1:0]        ws_x,
  output logic [LANE_W*N-1:0]        ws_w,
  input  logic [SUM_W-1:0]           ws_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEURONS-1:0]         out_fire,
  output logic [SUM_W*NEURONS-1:0]   out_sum
);
  localparam int XW = LANE_W * N;
  localparam logic [AW:0] NEU = NEURONS[AW:0];
  localparam logic [AW-1:0] LAST = AW'(NEURONS - 1);
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] wbank_q [NEURONS];
  logic [XW-1:0] wbank_d [NEURONS];
  logic [SUM_W-1:0] sum_q [NEURONS];
  logic [SUM_W-1:0] sum_d [NEURONS];
  logic [NEURONS-1:0] fire_q, fire_d;
  logic [AW-1:0] iss_q, iss_d;
  logic [AW:0] cap_q, cap_d;
  tag_t tag_in, tag_out;
  logic cap_en;
  logic [AW-1:0] cap_idx;
  tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );
  // the range guard keeps a corrupt tag from touching an unbuilt neuron slot
  assign cap_en = tag_out.valid && (tag_out.idx < IDX_W'(NEURONS));
  assign cap_idx = tag_out.idx[AW-1:0];
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    wbank_d = wbank_q;
    sum_d = sum_q;
    fire_d = fire_q;
    iss_d = iss_q;
    cap_d = cap_q;
    tag_in = '0;
    if (state_q == S_IDLE && wr_en && {1'b0, wr_addr} < NEU) wbank_d[wr_addr] = wr_w;
    if (cap_en) begin
      sum_d[cap_idx] = ws_sum;
      fire_d[cap_idx] = $signed(ws_sum) >= $signed(thresh);
      cap_d = cap_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        x_d = in_x;
        iss_d = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tag_in.valid = 1'b1;
        tag_in.idx = IDX_W'(iss_q);
        iss_d = iss_q == LAST ? '0 : iss_q + 1'b1;
        state_d = iss_q == LAST ? S_WAIT : S_ISSUE;
      end
      S_WAIT: if (cap_d == NEU) begin
        cap_d = '0;
        state_d = S_OUT;
      end
      S_OUT: state_d = out_ready ? S_IDLE : S_OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q <= '0;
      wbank_q <= '{default: '0};
      sum_q <= '{default: '0};
      fire_q <= '0;
      iss_q <= '0;
      cap_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      wbank_q <= wbank_d;
      sum_q <= sum_d;
      fire_q <= fire_d;
      iss_q <= iss_d;
      cap_q <= cap_d;
    end
  end
  assign in_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign out_valid = state_q == S_OUT;
  assign ws_x = state_q == S_ISSUE ? x_q : '0;
  assign ws_w = state_q == S_ISSUE ? wbank_q[iss_q] : '0;
  assign out_fire = fire_q;
  for (genvar g = 0; g < NEURONS; g++) begin : g_sum
    assign out_sum[SUM_W*g +: SUM_W] = sum_q[g];
  end
endmodule

// File: tb/tb_perceptron_seq.sv
// tb_perceptron_seq: scoreboard bench with a pure-delay cascade model and a dot-product reference
module tb_perceptron_seq;
  localparam int N = 8;
  localparam int NEU = 4;
  localparam int L = 10;
  localparam int AW = 2;
  localparam int XW = 18 * N;
  typedef struct packed {
    logic [NEU-1:0] fire;
    logic [48*NEU-1:0] sum;
  } exp_t;
  logic clk = 0;
  logic rst, in_valid, in_ready, wr_en, busy, out_valid, out_ready;
  logic [XW-1:0] in_x, wr_w, ws_x, ws_w;
  logic [AW-1:0] wr_addr;
  logic [47:0] thresh, ws_sum;
  logic [NEU-1:0] out_fire;
  logic [48*NEU-1:0] out_sum;
  int checks = 0;
  int errors = 0;
  exp_t sb [$];
  exp_t mon_e;
  logic [XW-1:0] w_m [NEU];
  logic signed [47:0] dl [L];
  int cyc = 0;
  int last_rise = 0;
  bit have_last = 0;
  bit prev_v = 0;
  bit measure_en = 0;

  perceptron_seq #(.N(N), .NEURONS(NEU), .PIPE_LAT(L), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_w(wr_w), .busy(busy), .thresh(thresh),
    .ws_x(ws_x), .ws_w(ws_w), .ws_sum(ws_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_fire(out_fire), .out_sum(out_sum)
  );

  always #5 clk = ~clk;

  function automatic logic signed [47:0] dot(input logic [XW-1:0] x, input logic [XW-1:0] w);
    logic signed [47:0] s;
    logic signed [17:0] a, b;
    s = 0;
    for (int i = 0; i < N; i++) begin
      a = x[18*i +: 18];
      b = w[18*i +: 18];
      s = s + a * b;
    end
    return s;
  endfunction

  // external cascade: result of each presented pair appears L cycles later
  always @(posedge clk) begin
    dl[0] <= dot(ws_x, ws_w);
    for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
  end
  assign ws_sum = dl[L-1];

  function automatic exp_t model(input logic [XW-1:0] x, input logic signed [47:0] th);
    exp_t e;
    logic signed [47:0] s;
    for (int k = 0; k < NEU; k++) begin
      s = dot(x, w_m[k]);
      e.sum[48*k +: 48] = s;
      e.fire[k] = s >= th;
    end
    return e;
  endfunction

  function automatic logic [XW-1:0] fill(input logic [17:0] v);
    logic [XW-1:0] r;
    for (int i = 0; i < N; i++) r[18*i +: 18] = v;
    return r;
  endfunction

  function automatic logic [XW-1:0] rnd_vec();
    logic [XW-1:0] r;
    for (int i = 0; i < N; i++) r[18*i +: 18] = 18'($urandom());
    return r;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XW-1:0] w, input bit upd);
    wr_en = 1; wr_addr = a; wr_w = w;
    tick();
    wr_en = 0;
    if (upd) w_m[a] = w;
  endtask

  task automatic send(input logic [XW-1:0] x, input logic signed [47:0] th,
                      input bit do_wr, input logic [AW-1:0] a, input logic [XW-1:0] w);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("accept_wait", {191'b0, in_ready}, 192'd1);
    in_valid = 1; in_x = x; thresh = th;
    if (do_wr) begin wr_en = 1; wr_addr = a; wr_w = w; w_m[a] = w; end
    sb.push_back(model(x, th));
    tick();
    in_valid = 0; wr_en = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
  endtask

  task automatic reset_vals(input string t);
    chk({t, "_out_valid"}, out_valid, 0);
    chk({t, "_in_ready"}, in_ready, 1);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_out_fire"}, out_fire, 0);
    chk({t, "_out_sum"}, out_sum, 0);
    chk({t, "_ws_x"}, ws_x, 0);
    chk({t, "_ws_w"}, ws_w, 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst && out_valid && !prev_v && measure_en) begin
      if (have_last) chk("period", cyc - last_rise, 16);
      have_last = 1;
      last_rise = cyc;
    end
    prev_v = out_valid;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%0h expected=none", out_sum);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_fire", out_fire, mon_e.fire);
        chk("sb_sum", out_sum, mon_e.sum);
      end
    end
  end

  initial begin
    int n;
    bit stable, rdy_bad, quiet;
    logic [48*NEU-1:0] snap_s;
    logic [NEU-1:0] snap_f;
    logic [XW-1:0] x;
    logic signed [47:0] th;
    logic [63:0] r;
    rst = 1; in_valid = 0; in_x = 0; wr_en = 0; wr_addr = 0; wr_w = 0; thresh = 0; out_ready = 1;
    for (int k = 0; k < NEU; k++) w_m[k] = 0;
    tick(); tick();
    reset_vals("reset");
    rst = 0;
    // all-ones weights, x=2, thresh at the exact sum
    for (int k = 0; k < NEU; k++) wr(AW'(k), fill(18'd1), 1);
    out_ready = 0;
    send(fill(18'd2), 48'sd16, 0, 0, 0);
    wait_valid(n);
    chk("latency", n, 14);
    for (int k = 0; k < NEU; k++) chk("sum_ones", out_sum[48*k +: 48], 48'd16);
    chk("fire_ones", out_fire, 4'b1111);
    snap_s = out_sum; snap_f = out_fire; stable = 1; rdy_bad = 0;
    in_valid = 1; in_x = rnd_vec();
    repeat (20) begin
      tick();
      if (out_sum !== snap_s || out_fire !== snap_f || !out_valid) stable = 0;
      if (in_ready) rdy_bad = 1;
    end
    in_valid = 0;
    chk("hold_stable", stable, 1);
    chk("hold_in_ready_low", rdy_bad, 0);
    out_ready = 1;
    tick();
    chk("ready_after_handshake", in_ready, 1);
    // negative weights on neuron 2
    wr(2, fill(18'h3FFFF), 1);
    send(fill(18'd2), 48'sd0, 0, 0, 0);
    wait_valid(n);
    chk("latency_neg", n, 14);
    chk("fire_neg", out_fire, 4'b1011);
    chk("sum2_neg", out_sum[96 +: 48], 48'hFFFF_FFFF_FFF0);
    // write while issuing is dropped
    send(fill(18'd2), 48'sd0, 0, 0, 0);
    chk("busy_in_issue", busy, 1);
    wr(1, fill(18'd3), 0);
    wait_valid(n);
    chk("sum1_old_weight", out_sum[48 +: 48], 48'd16);
    // write in the accept cycle takes effect
    send(fill(18'd2), 48'sd0, 1, 1, fill(18'd3));
    wait_valid(n);
    chk("sum1_same_cycle_write", out_sum[48 +: 48], 48'd48);
    chk("fire_same_cycle_write", out_fire, 4'b1011);
    // reset in cycle 8, mid-flight
    send(fill(18'd2), 48'sd0, 0, 0, 0);
    repeat (7) tick();
    rst = 1;
    tick();
    reset_vals("midreset");
    rst = 0;
    sb.delete();
    for (int k = 0; k < NEU; k++) w_m[k] = 0;
    quiet = 1;
    repeat (20) begin
      tick();
      if (out_valid || out_sum !== '0 || out_fire !== '0) quiet = 0;
    end
    chk("no_stale_capture", quiet, 1);
    for (int k = 0; k < NEU; k++) wr(AW'(k), rnd_vec(), 1);
    send(rnd_vec(), 48'sd0, 0, 0, 0);
    wait_valid(n);
    chk("latency_after_reset", n, 14);
    // back-to-back random vectors with out_ready tied high
    measure_en = 1;
    for (int v = 0; v < 8; v++) begin
      x = rnd_vec();
      r = {$urandom(), $urandom()};
      th = $urandom_range(0, 1) ? dot(x, w_m[$urandom_range(0, NEU-1)]) : 48'($signed(r[39:0]));
      send(x, th, 0, 0, 0);
    end
    n = 0;
    while (sb.size() > 0 && n < 100) begin tick(); n++; end
    chk("drain", sb.size(), 0);
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/perceptron_seq.md
# perceptron_seq

Sequencer for the pipelined `weighted_sum` DSP48 cascade. It time-multiplexes the single N-slice datapath across NEURONS perceptrons that share one input vector. It holds a per-neuron weight bank, issues one neuron per cycle into the cascade, and tracks in-flight neurons with a tag pipeline. It captures each 48-bit sum, applies a signed threshold, and returns the full result vector through a valid/ready handshake. It sits between the input feature source and the activation/readout logic of the single-layer perceptron.

## Interface
- N, 8, number of 18-bit lanes per vector (matches cascade width)
- NEURONS, 4, number of perceptrons sharing the datapath
- PIPE_LAT, 10, cycles from `ws_x`/`ws_w` presented to matching `ws_sum` valid
- AW, 2, weight-bank address width; requires 2^AW ≥ NEURONS
- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector offered
- in_ready  out  1  high only in IDLE
- in_x  in  18*N  input vector, lane i at [18i+17:18i], signed
- wr_en  in  1  weight write strobe
- wr_addr  in  AW  neuron index
- wr_w  in  18*N  weight vector for that neuron
- busy  out  1  high whenever state ≠ IDLE
- thresh  in  48  signed firing threshold, sampled at capture
- ws_x  out  18*N  to cascade x
- ws_w  out  18*N  to cascade w
- ws_sum  in  48  cascade result, signed
- out_valid  out  1  results ready
- out_ready  in  1  consumer accepts
- out_fire  out  NEURONS  bit k = (sum_k ≥ thresh), signed compare
- out_sum  out  48*NEURONS  sum_k at [48k+47:48k]

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: in_ready=1. On in_valid, latch in_x into x_reg and go to ISSUE with issue counter k=0.
- ISSUE: drive ws_x=x_reg and ws_w=wbank[k]. Push tag {valid=1, idx=k} into the PIPE_LAT-deep tag shift register. Increment k. After k=NEURONS-1 is issued, go to WAIT.
- Outside ISSUE: ws_x, ws_w and pushed tags are all zero.
- Tag pipeline: when the tag exiting the shift register is valid, store ws_sum into sum_reg[idx]. Store ($signed(ws_sum) ≥ $signed(thresh)) into fire_reg[idx]. Increment the capture counter.
- WAIT: when the capture counter reaches NEURONS, go to OUT. Clear both counters.
- OUT: out_valid=1. out_fire and out_sum reflect fire_reg and sum_reg. On out_ready, go to IDLE.
- Weight writes: accepted only when state=IDLE and wr_en=1. They are ignored (dropped) when busy=1, or when wr_addr ≥ NEURONS.
- Same-cycle in_valid and wr_en in IDLE: the write commits and the vector is accepted. ISSUE starts the next cycle, so it uses the new weight.
- No arithmetic is performed here. The sum width is the cascade's 48 bits and the compare is full-width signed.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, busy=0, out_valid=0
  - out_fire=0, out_sum=0, ws_x=0, ws_w=0
  - tag pipeline cleared, counters=0, weight bank all zero
- Reset mid-operation aborts everything. In-flight cascade results arriving afterwards are discarded, because their tags are cleared.
- Accept at edge 0. Neuron k is issued in cycle 1+k and captured in cycle 1+k+PIPE_LAT.
- out_valid rises in cycle NEURONS+PIPE_LAT+1. With defaults this is cycle 15.
- out_valid holds, with stable data, until out_ready is seen. The next in_ready is the cycle after the handshake.
- Throughput is one vector per NEURONS+PIPE_LAT+2 cycles. The block does not overlap vectors.
- out_ready high before out_valid has no effect.

## Structure
- Shared package `perceptron_pkg`:
  - state enum
  - lane width 18 and sum width 48
  - tag struct {valid, idx}
- One natural sub-module: `tag_pipe`, a parameterised PIPE_LAT-deep shift register of tags with synchronous clear.
- The cascade itself stays outside this block. The bench instantiates it, or models it as a pure PIPE_LAT delay of Σ x_i·w_i.

## Test plan
- Reset, then write neuron 0..3 weights to all-ones lanes. Apply x lanes = 2 with thresh=16, using the delay model. Required response: out_valid at cycle 15, each out_sum=16, out_fire=4'b1111.
- Negative weights (−1) on neuron 2 with thresh=0. Required response: sum_2=−16 (48-bit sign-extended), out_fire=4'b1011.
- Hold out_ready low for 20 cycles after out_valid. Required response: outputs stable, in_ready=0, and in_valid is not accepted until 1 cycle after the handshake.
- wr_en during ISSUE with new weights. Required response: the write is ignored and results match the old weights. A write in the same cycle as the IDLE accept takes effect.
- Assert rst in cycle 8, mid-WAIT. Required response: all outputs return to reset values next cycle, no stale capture appears, and a fresh vector completes normally.
- Back-to-back vectors with out_ready tied high. Required response: out_valid pulses every NEURONS+PIPE_LAT+2 = 16 cycles and every result is correct.
